ddram_arbiter: RTL and testbench
================================

Name: ddram_arbiter

Overview:
- Two-requester arbiter for the shared DDRAM (DDR3 burst) port in the DDRAM clock domain; sits between core-side burst masters (e.g. burst writer, video fetch) and the DDRAM_* top-level signals.
- Grants whole bursts round-robin; holds grant until the last write beat is accepted or the last read beat is returned.
- Passes commands through combinationally to the granted requester; the non-granted requester sees busy.

Parameters:
- AW, 29, address width (64-bit word address).
- DW, 64, data width.
- BW, 8, burst count width.
- WD_CYCLES, 4096, read watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  DDRAM clock (drives DDRAM_CLK domain).
- reset_n  in  1  asynchronous, active-low reset.
- pN_addr  in  AW  requester N address, N=0,1 (valid with first write beat or read command).
- pN_burstcnt  in  BW  requester N beat count, 1..2^BW-1.
- pN_rd  in  1  requester N read command.
- pN_we  in  1  requester N write beat.
- pN_din  in  DW  requester N write data.
- pN_be  in  DW/8  requester N byte enables.
- pN_busy  out  1  stall to requester N.
- pN_dout_ready  out  1  read beat valid for requester N.
- dout  out  DW  read data, broadcast to both requesters.
- ddr_busy  in  1  DDRAM_BUSY.
- ddr_addr  out  AW  to DDRAM_ADDR.
- ddr_burstcnt  out  BW  to DDRAM_BURSTCNT.
- ddr_rd  out  1  to DDRAM_RD.
- ddr_we  out  1  to DDRAM_WE.
- ddr_din  out  DW  to DDRAM_DIN.
- ddr_be  out  DW/8  to DDRAM_BE.
- ddr_dout  in  DW  DDRAM_DOUT.
- ddr_dout_ready  in  1  DDRAM_DOUT_READY.
- grant  out  1  current or last granted requester.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; grant=1, so p0 wins the first tie.
  - beat counter 0; err=0; pN_busy=1; pN_dout_ready=0; ddr_rd=0; ddr_we=0.
  - Reset mid-burst aborts immediately; the DDR controller-side burst is left incomplete (system-level reset only).
- Transfer rule: a beat/command transfers when rd or we is high and ddr_busy=0 on a rising clk.
- States:
  - IDLE:
    - pN_busy=1 for both requesters; ddr_rd and ddr_we forced 0.
    - reqN = pN_rd | pN_we.
    - If exactly one reqN: grant<=N.
    - If both: grant<=~grant (round-robin).
    - Next state GRANT. Request-to-DDRAM latency is 1 cycle.
  - GRANT:
    - Granted port's addr/burstcnt/rd/we/din/be drive ddr_* combinationally; granted pN_busy=ddr_busy; other pN_busy=1.
    - First transfer with we: cnt<=burstcnt-1; go to IDLE if burstcnt==1, else WBURST.
    - Transfer with rd: cnt<=burstcnt; go to RDATA.
    - If rd and we are both high, write takes precedence.
    - burstcnt==0 is treated as 1 and sets err.
  - WBURST:
    - Same passthrough, with ddr_rd forced 0.
    - Each accepted we beat decrements cnt; the beat accepted with cnt==1 returns to IDLE.
    - pN_rd is ignored in this state.
  - RDATA:
    - ddr_rd and ddr_we forced 0; both pN_busy=1.
    - Each ddr_dout_ready pulses pN_dout_ready of the granted requester only, same cycle, and decrements cnt; cnt reaching 0 returns to IDLE.
- dout = ddr_dout at all times (combinational).
- ddr_dout_ready outside RDATA is ignored and sets err.
- cnt width is BW; there is no wrap, because the count is bounded by burstcnt.
- After a grant ends there is always one IDLE cycle, so back-to-back bursts from the same requester incur a 1-cycle bubble.

Optional Feature:
- DDRAM_ARB_WATCHDOG_EN defined:
  - A watchdog counter runs in RDATA and resets on each dout_ready.
  - Reaching WD_CYCLES sets err and forces IDLE, releasing the grant.
- Undefined:
  - No watchdog; RDATA waits indefinitely.
  - WD_CYCLES is unused.

Test Plan:
- p0 write burstcnt=128, ddr_busy=0, p1 idle -> 128 consecutive ddr_we beats after a 1-cycle IDLE, ddr_addr=p0_addr, p1_busy=1 throughout, then IDLE.
- p0 and p1 both assert rd with burstcnt=4 in the same cycle after reset -> p0 granted first; 4 beats return only on p0_dout_ready; then p1 granted.
- p1 write burstcnt=8 with ddr_busy toggled high on beats 3 and 5 -> exactly 8 beats transferred; p1_busy mirrors ddr_busy; data order preserved.
- ddr_dout_ready pulse while IDLE -> no pN_dout_ready asserted, err=1.
- reset_n low during WBURST at beat 2 of 16 -> asynchronously ddr_we=0, both busy=1, grant=1, err=0.
- With DDRAM_ARB_WATCHDOG_EN and WD_CYCLES=16: read burstcnt=4, only 2 beats returned -> after 16 idle cycles err=1 and state is IDLE; next p1 request is granted.

Source files
------------

// File: rtl/ddram_arbiter.sv
// Two-requester round-robin burst arbiter for the shared DDRAM port; whole bursts are granted, 1-cycle request-to-DDRAM latency.
// Backpressure: granted requester sees ddr_busy, the other sees busy=1. Optional read watchdog: define DDRAM_ARB_WATCHDOG_EN.
module ddram_arbiter #(
  parameter int AW        = 29,
  parameter int DW        = 64,
  parameter int BW        = 8,
  parameter int WD_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [AW-1:0]     p0_addr,
  input  logic [BW-1:0]     p0_burstcnt,
  input  logic              p0_rd,
  input  logic              p0_we,
  input  logic [DW-1:0]     p0_din,
  input  logic [DW/8-1:0]   p0_be,
  output logic              p0_busy,
  output logic              p0_dout_ready,

  input  logic [AW-1:0]     p1_addr,
  input  logic [BW-1:0]     p1_burstcnt,
  input  logic              p1_rd,
  input  logic              p1_we,
  input  logic [DW-1:0]     p1_din,
  input  logic [DW/8-1:0]   p1_be,
  output logic              p1_busy,
  output logic              p1_dout_ready,

  output logic [DW-1:0]     dout,

  input  logic              ddr_busy,
  output logic [AW-1:0]     ddr_addr,
  output logic [BW-1:0]     ddr_burstcnt,
  output logic              ddr_rd,
  output logic              ddr_we,
  output logic [DW-1:0]     ddr_din,
  output logic [DW/8-1:0]   ddr_be,
  input  logic [DW-1:0]     ddr_dout,
  input  logic              ddr_dout_ready,

  output logic              grant,
  output logic              err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_WBURST = 2'd2;
  localparam logic [1:0] S_RDATA  = 2'd3;

  logic [1:0]      state;
  logic [BW-1:0]   cnt;

  logic [AW-1:0]   sel_addr;
  logic [BW-1:0]   sel_bc;
  logic            sel_rd;
  logic            sel_we;
  logic [DW-1:0]   sel_din;
  logic [DW/8-1:0] sel_be;
  logic            bc_zero;
  logic [BW-1:0]   bc_eff;
  logic            passthru;
  logic            port_busy;
  logic            rdata_beat;
  logic            xfer_we;
  logic            xfer_rd;
  logic            req0;
  logic            req1;

  always_comb begin
    sel_addr = grant ? p1_addr     : p0_addr;
    sel_bc   = grant ? p1_burstcnt : p0_burstcnt;
    sel_rd   = grant ? p1_rd       : p0_rd;
    sel_we   = grant ? p1_we       : p0_we;
    sel_din  = grant ? p1_din      : p0_din;
    sel_be   = grant ? p1_be       : p0_be;
  end

  // A zero burst count is carried out as a single beat.
  assign bc_zero = (sel_bc == '0);
  assign bc_eff  = bc_zero ? BW'(1) : sel_bc;

  assign passthru     = (state == S_GRANT) || (state == S_WBURST);
  assign ddr_addr     = sel_addr;
  assign ddr_burstcnt = bc_eff;
  assign ddr_din      = sel_din;
  assign ddr_be       = sel_be;
  assign ddr_we       = passthru & sel_we;
  assign ddr_rd       = (state == S_GRANT) & sel_rd & ~sel_we;

  assign port_busy = passthru ? ddr_busy : 1'b1;
  assign p0_busy   = grant ? 1'b1 : port_busy;
  assign p1_busy   = grant ? port_busy : 1'b1;

  assign rdata_beat    = (state == S_RDATA) & ddr_dout_ready;
  assign p0_dout_ready = rdata_beat & ~grant;
  assign p1_dout_ready = rdata_beat &  grant;
  assign dout          = ddr_dout;

  assign xfer_we = ddr_we & ~ddr_busy;
  assign xfer_rd = ddr_rd & ~ddr_busy;
  assign req0    = p0_rd | p0_we;
  assign req1    = p1_rd | p1_we;

`ifdef DDRAM_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);

  logic [WDW-1:0] wd_cnt;
  logic           wd_fire;

  assign wd_fire = (state == S_RDATA) && !ddr_dout_ready && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state != S_RDATA || ddr_dout_ready) begin
      wd_cnt <= '0;
    end else if (!wd_fire) begin
      wd_cnt <= wd_cnt + WDW'(1);
    end
  end
`else
  logic wd_fire;
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      grant <= 1'b1;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      if (ddr_dout_ready && state != S_RDATA) begin
        err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (req0 && req1) begin
            grant <= ~grant;
            state <= S_GRANT;
          end else if (req0) begin
            grant <= 1'b0;
            state <= S_GRANT;
          end else if (req1) begin
            grant <= 1'b1;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (xfer_we) begin
            cnt   <= bc_eff - BW'(1);
            state <= (bc_eff == BW'(1)) ? S_IDLE : S_WBURST;
            if (bc_zero) err <= 1'b1;
          end else if (xfer_rd) begin
            cnt   <= bc_eff;
            state <= S_RDATA;
            if (bc_zero) err <= 1'b1;
          end
        end
        S_WBURST: begin
          if (xfer_we) begin
            cnt <= cnt - BW'(1);
            if (cnt <= BW'(1)) state <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (ddr_dout_ready) begin
            cnt <= cnt - BW'(1);
            if (cnt <= BW'(1)) state <= S_IDLE;
          end else if (wd_fire) begin
            // Stalled read: drop the grant so the other requester is not starved.
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed self-checking bench for ddram_arbiter; inputs driven 2 time units after posedge, outputs checked 1 unit later.
module tb_ddram_arbiter;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     p0_addr, p1_addr;
  logic [BW-1:0]     p0_burstcnt, p1_burstcnt;
  logic              p0_rd, p0_we, p1_rd, p1_we;
  logic [DW-1:0]     p0_din, p1_din;
  logic [DW/8-1:0]   p0_be, p1_be;
  logic              p0_busy, p1_busy, p0_dout_ready, p1_dout_ready;
  logic [DW-1:0]     dout;
  logic              ddr_busy;
  logic [AW-1:0]     ddr_addr;
  logic [BW-1:0]     ddr_burstcnt;
  logic              ddr_rd, ddr_we;
  logic [DW-1:0]     ddr_din;
  logic [DW/8-1:0]   ddr_be;
  logic [DW-1:0]     ddr_dout;
  logic              ddr_dout_ready;
  logic              grant, err;

  int tests = 0;
  int fails = 0;

  ddram_arbiter #(.AW(AW), .DW(DW), .BW(BW), .WD_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_addr(p0_addr), .p0_burstcnt(p0_burstcnt), .p0_rd(p0_rd), .p0_we(p0_we),
    .p0_din(p0_din), .p0_be(p0_be), .p0_busy(p0_busy), .p0_dout_ready(p0_dout_ready),
    .p1_addr(p1_addr), .p1_burstcnt(p1_burstcnt), .p1_rd(p1_rd), .p1_we(p1_we),
    .p1_din(p1_din), .p1_be(p1_be), .p1_busy(p1_busy), .p1_dout_ready(p1_dout_ready),
    .dout(dout), .ddr_busy(ddr_busy), .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt),
    .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_din(ddr_din), .ddr_be(ddr_be),
    .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready), .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int k;
    int cyc;
    reset_n = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_burstcnt = '0; p1_burstcnt = '0;
    p0_rd = 0; p0_we = 0; p1_rd = 0; p1_we = 0;
    p0_din = '0; p1_din = '0; p0_be = '1; p1_be = '1;
    ddr_busy = 0; ddr_dout = '0; ddr_dout_ready = 0;
    repeat (2) tick();
    #1;
    check("rst_grant", grant, 1);
    check("rst_p0_busy", p0_busy, 1);
    check("rst_p1_busy", p1_busy, 1);
    check("rst_ddr_we", ddr_we, 0);
    check("rst_ddr_rd", ddr_rd, 0);
    check("rst_err", err, 0);
    check("rst_dout_rdy", {p0_dout_ready, p1_dout_ready}, 0);
    reset_n = 1'b1;
    tick();

    // p0 write burst of 128 beats
    p0_addr = 29'h0123_4560; p0_burstcnt = 8'd128; p0_we = 1; p0_din = 64'h1000;
    #1;
    check("wr128_idle_busy", p0_busy, 1);
    check("wr128_idle_we", ddr_we, 0);
    tick();
    for (int i = 0; i < 128; i++) begin
      p0_din = 64'h1000 + 64'(i);
      #1;
      check("wr128_we", ddr_we, 1);
      check("wr128_din", ddr_din, 64'h1000 + 64'(i));
      check("wr128_addr", ddr_addr, 29'h0123_4560);
      check("wr128_p1_busy", p1_busy, 1);
      check("wr128_p0_busy", p0_busy, 0);
      tick();
    end
    p0_we = 0;
    #1;
    check("wr128_end_busy", p0_busy, 1);
    check("wr128_end_we", ddr_we, 0);
    check("wr128_grant", grant, 0);

    // simultaneous reads after reset: p0 first, then p1
    do_reset();
    p0_addr = 29'h100; p1_addr = 29'h200; p0_burstcnt = 8'd4; p1_burstcnt = 8'd4;
    p0_rd = 1; p1_rd = 1;
    tick();
    #1;
    check("rd_grant0", grant, 0);
    check("rd_ddr_rd0", ddr_rd, 1);
    check("rd_addr0", ddr_addr, 29'h100);
    check("rd_p0_busy", p0_busy, 0);
    check("rd_p1_busy", p1_busy, 1);
    tick();
    p0_rd = 0;
    #1;
    check("rd_rdata_rd", ddr_rd, 0);
    check("rd_rdata_busy", {p0_busy, p1_busy}, 2'b11);
    for (int b = 0; b < 4; b++) begin
      ddr_dout_ready = 1; ddr_dout = 64'hA0 + 64'(b);
      #1;
      check("rd0_p0_rdy", p0_dout_ready, 1);
      check("rd0_p1_rdy", p1_dout_ready, 0);
      check("rd0_dout", dout, 64'hA0 + 64'(b));
      tick();
      ddr_dout_ready = 0;
      if (b < 3) begin
        #1;
        check("rd0_gap_rdy", p0_dout_ready, 0);
        tick();
      end
    end
    #1;
    check("rd_idle_p1_busy", p1_busy, 1);
    check("rd_idle_ddr_rd", ddr_rd, 0);
    tick();
    #1;
    check("rd_grant1", grant, 1);
    check("rd_ddr_rd1", ddr_rd, 1);
    check("rd_addr1", ddr_addr, 29'h200);
    check("rd_p1_busy_g", p1_busy, 0);
    check("rd_p0_busy_g", p0_busy, 1);
    tick();
    p1_rd = 0;
    for (int b = 0; b < 4; b++) begin
      ddr_dout_ready = 1; ddr_dout = 64'hB0 + 64'(b);
      #1;
      check("rd1_p1_rdy", p1_dout_ready, 1);
      check("rd1_p0_rdy", p0_dout_ready, 0);
      tick();
    end
    ddr_dout_ready = 0;
    #1;
    check("rd_done_err", err, 0);

    // p1 write of 8 beats with ddr_busy stalls on beats 3 and 5
    p1_addr = 29'h300; p1_burstcnt = 8'd8; p1_we = 1; p1_din = 64'hC0;
    tick();
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 20) begin
      ddr_busy = ((k == 2 && cyc == 2) || (k == 4 && cyc == 5));
      p1_din = 64'hC0 + 64'(k);
      #1;
      check("wr8_busy_mirror", p1_busy, ddr_busy);
      check("wr8_p0_busy", p0_busy, 1);
      check("wr8_we", ddr_we, 1);
      check("wr8_din", ddr_din, 64'hC0 + 64'(k));
      tick();
      if (!ddr_busy) k++;
      cyc++;
    end
    ddr_busy = 0; p1_we = 0;
    #1;
    check("wr8_beats", k, 8);
    check("wr8_cycles", cyc, 10);
    check("wr8_idle_busy", p1_busy, 1);
    check("wr8_err", err, 0);

    // stray dout_ready while IDLE
    ddr_dout_ready = 1;
    #1;
    check("stray_rdy", {p0_dout_ready, p1_dout_ready}, 0);
    tick();
    ddr_dout_ready = 0;
    #1;
    check("stray_err", err, 1);
    tick();
    #1;
    check("stray_err_sticky", err, 1);

    // async reset during a 16-beat write at beat 2
    p0_addr = 29'h400; p0_burstcnt = 8'd16; p0_we = 1; p0_din = 64'hD0;
    tick();
    tick();
    tick();
    #1;
    check("wb16_we_pre", ddr_we, 1);
    check("wb16_grant_pre", grant, 0);
    reset_n = 0;
    #1;
    check("wb16_rst_we", ddr_we, 0);
    check("wb16_rst_busy", {p0_busy, p1_busy}, 2'b11);
    check("wb16_rst_grant", grant, 1);
    check("wb16_rst_err", err, 0);
    p0_we = 0;
    tick();
    reset_n = 1;
    tick();

    // zero burst count: single beat, err set
    p1_addr = 29'h500; p1_burstcnt = 8'd0; p1_we = 1; p1_din = 64'hE0;
    tick();
    #1;
    check("bc0_we", ddr_we, 1);
    check("bc0_burstcnt", ddr_burstcnt, 1);
    tick();
    p1_we = 0;
    #1;
    check("bc0_idle_busy", p1_busy, 1);
    check("bc0_err", err, 1);

`ifdef DDRAM_ARB_WATCHDOG_EN
    do_reset();
    p0_addr = 29'h600; p0_burstcnt = 8'd4; p0_rd = 1;
    tick();
    tick();
    p0_rd = 0;
    ddr_dout_ready = 1;
    tick();
    tick();
    ddr_dout_ready = 0;
    repeat (15) tick();
    #1;
    check("wd_err_pre", err, 0);
    tick();
    #1;
    check("wd_err", err, 1);
    p1_addr = 29'h700; p1_burstcnt = 8'd1; p1_rd = 1;
    #1;
    check("wd_idle_busy", p1_busy, 1);
    tick();
    #1;
    check("wd_grant1", grant, 1);
    check("wd_p1_rd", ddr_rd, 1);
    p1_rd = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
